avalon_mem_pattern_master: RTL and testbench

- Avalon-MM master that drives the single-port on-chip RAM slave: fills an address window with a deterministic pattern, reads it back and compares.
- Used for power-on memory self-test and bring-up diagnostics; sits beside the Nios core on the same RAM slave port.
- The slave has fixed read latency, no waitrequest and an unregistered output; this master matches that.

---
 rtl/avalon_mem_pattern_master_if.sv | 27 ++
 rtl/avalon_mem_pattern_master.sv | 197 +++++++++++++++++++
 tb/tb_avalon_mem_pattern_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mem_pattern_master_if.sv
// Avalon-MM bus between the pattern master and the single-port on-chip RAM slave.
// Latency: pure wiring, no storage.
// Backpressure: none on the bus itself; avm_clken carries the stall to the RAM.
interface avalon_mem_pattern_master_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_clken;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address, avm_chipselect, avm_write, avm_writedata,
               avm_byteenable, avm_clken,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write, avm_writedata,
               avm_byteenable, avm_clken,
        output avm_readdata
    );
endinterface

// File: rtl/avalon_mem_pattern_master.sv
// Memory self-test master: writes a seed-derived pattern over an address window, reads it back, counts mismatches.
// Latency: start at edge k -> done in cycle k+2N+READ_LATENCY+1 (cycle k+1 when word_count is 0).
// Backpressure: hold freezes FSM, index, delay line and bus outputs and drops avm_clken; the RAM has no waitrequest.
// Optional: define FIRST_ERR_CAPTURE_EN to add first_err_addr/first_err_data capture of the first mismatch.
module avalon_mem_pattern_master #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 30720,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              hold,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
`ifdef FIRST_ERR_CAPTURE_EN
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
`endif
    avalon_mem_pattern_master_if.master avm
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       last_idx;
    logic [DATA_W-1:0] seed_q;
    logic [15:0]       idx;

    // Expected-data delay line, aligned with the RAM read latency.
    logic [READ_LATENCY-1:0] dl_vld;
    logic [DATA_W-1:0]       dl_dat [READ_LATENCY];

    logic        advance;
    logic        start_acc;
    logic        push;
    logic        dl_rest_vld;
    logic        mismatch;
    logic [15:0] err_next;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s, input logic [15:0] i);
        return s ^ {~i, i};
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    // hold has no effect in IDLE so a start is never lost.
    assign advance   = ~hold | (state == IDLE);
    assign start_acc = (state == IDLE) & start;
    assign push      = (state == READ);
    assign mismatch  = dl_vld[READ_LATENCY-1] & (avm.avm_readdata != dl_dat[READ_LATENCY-1]);
    assign err_next  = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

    assign avm.avm_byteenable = 4'hF;
    assign avm.avm_clken      = ~hold;

    // Any entry still in flight other than the one leaving this cycle keeps DRAIN waiting.
    always_comb begin
        dl_rest_vld = 1'b0;
        for (int s = 0; s < READ_LATENCY - 1; s++) begin
            dl_rest_vld = dl_rest_vld | dl_vld[s];
        end
    end

    // Shift expected data alongside each read so it meets avm_readdata exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_vld <= '0;
            for (int s = 0; s < READ_LATENCY; s++) dl_dat[s] <= '0;
        end else if (advance) begin
            dl_vld[0] <= push;
            dl_dat[0] <= pattern(seed_q, idx);
            for (int s = 1; s < READ_LATENCY; s++) begin
                dl_vld[s] <= dl_vld[s-1];
                dl_dat[s] <= dl_dat[s-1];
            end
        end
    end

    // Sequencer: write pass, read pass, drain the delay line, then report.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            err_count          <= '0;
            base_q             <= '0;
            last_idx           <= '0;
            seed_q             <= '0;
            idx                <= '0;
            avm.avm_address    <= '0;
            avm.avm_chipselect <= 1'b0;
            avm.avm_write      <= 1'b0;
            avm.avm_writedata  <= '0;
        end else if (advance) begin
            err_count <= err_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        last_idx  <= word_count - 16'd1;
                        seed_q    <= seed;
                        idx       <= '0;
                        err_count <= '0;
                        if (word_count == 16'd0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state              <= WRITE;
                            busy               <= 1'b1;
                            pass               <= 1'b0;
                            avm.avm_chipselect <= 1'b1;
                            avm.avm_write      <= 1'b1;
                            avm.avm_address    <= base_addr;
                            avm.avm_writedata  <= pattern(seed, 16'd0);
                        end
                    end
                end
                WRITE: begin
                    if (idx == last_idx) begin
                        idx             <= '0;
                        state           <= READ;
                        avm.avm_write   <= 1'b0;
                        avm.avm_address <= base_q;
                    end else begin
                        idx               <= idx + 16'd1;
                        avm.avm_address   <= next_addr(avm.avm_address);
                        avm.avm_writedata <= pattern(seed_q, idx + 16'd1);
                    end
                end
                READ: begin
                    if (idx == last_idx) begin
                        state              <= DRAIN;
                        avm.avm_chipselect <= 1'b0;
                    end else begin
                        idx             <= idx + 16'd1;
                        avm.avm_address <= next_addr(avm.avm_address);
                    end
                end
                DRAIN: begin
                    if (!dl_rest_vld) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_next == 16'd0);
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIRST_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] dl_adr [READ_LATENCY];

    // Carry each read address down the delay line so a mismatch can name its word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < READ_LATENCY; s++) dl_adr[s] <= '0;
        end else if (advance) begin
            dl_adr[0] <= avm.avm_address;
            for (int s = 1; s < READ_LATENCY; s++) dl_adr[s] <= dl_adr[s-1];
        end
    end

    // Latch only the first mismatch of a test; cleared when a new test is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (start_acc) begin
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (advance && mismatch && err_count == 16'd0) begin
            first_err_addr <= dl_adr[READ_LATENCY-1];
            first_err_data <= avm.avm_readdata;
        end
    end
`endif
endmodule

// File: tb/tb_avalon_mem_pattern_master.sv
// Self-checking bench for avalon_mem_pattern_master: directed vector table, hand sequences, randomized runs.
// Latency: all checks are cycle-counted from the edge that samples start.
// Backpressure: hold is driven from the vectors to exercise stalls.
module tb_avalon_mem_pattern_master;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 30720;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       word_count = '0;
    logic [31:0]       seed = '0;
    logic              busy, done, pass;
    logic [15:0]       err_count;
`ifdef FIRST_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] first_err_addr;
    logic [31:0]       first_err_data;
`endif

    avalon_mem_pattern_master_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    avalon_mem_pattern_master #(
        .ADDR_W(ADDR_W), .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hold(hold),
        .base_addr(base_addr), .word_count(word_count), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
`ifdef FIRST_ERR_CAPTURE_EN
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
`endif
        .avm(bus)
    );

    always #5 clk = ~clk;

    // RAM slave model: one-cycle read latency, clken gating, optional stuck bit at word 5.
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;
    bit          fault_en = 1'b0;
    int          wr_a_q[$];
    logic [31:0] wr_d_q[$];
    int          rd_total = 0;

    assign bus.avm_readdata = rd_q;

    always @(posedge clk) begin
        if (bus.avm_clken && bus.avm_chipselect) begin
            if (bus.avm_write) begin
                mem[bus.avm_address] <= bus.avm_writedata;
                wr_a_q.push_back(int'(bus.avm_address));
                wr_d_q.push_back(bus.avm_writedata);
            end else begin
                rd_q <= mem[bus.avm_address] ^ {31'd0, (fault_en && bus.avm_address == 15'd5)};
                rd_total++;
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] s, input int i);
        logic [15:0] w;
        w = 16'(i);
        return s ^ {~w, w};
    endfunction

    // Reference: replay the whole test on a sparse memory image and count mismatching words.
    task automatic model(input int b, input int n, input logic [31:0] sd, input bit flt,
                         output logic [15:0] e, output logic [14:0] fa, output logic [31:0] fd);
        logic [31:0] img [int];
        logic [31:0] got;
        int          a;
        e = '0; fa = '0; fd = '0;
        for (int i = 0; i < n; i++) img[(b + i) % DEPTH] = pat(sd, i);
        for (int i = 0; i < n; i++) begin
            a   = (b + i) % DEPTH;
            got = img[a] ^ ((flt && a == 5) ? 32'd1 : 32'd0);
            if (got != pat(sd, i)) begin
                if (e == 16'd0) begin
                    fa = 15'(a);
                    fd = got;
                end
                e = e + 16'd1;
            end
        end
    endtask

    task automatic run_test(input logic [14:0] b, input logic [15:0] n, input logic [31:0] sd, input bit flt,
                            input int hold_at, input int hold_len, input int restart_at,
                            input int exp_done, input logic [15:0] exp_err, input bit exp_pass,
                            input logic [14:0] exp_fa, input logic [31:0] exp_fd);
        int          done_cyc, dones, wr_mark, rd_mark, nw, bound;
        logic [14:0] snap_a;
        logic [31:0] snap_d;
        logic        snap_cs, snap_w;
        done_cyc = -1; dones = 0;
        snap_a = '0; snap_d = '0; snap_cs = 1'b0; snap_w = 1'b0;
        bound    = exp_done + 20;
        fault_en = flt;
        wr_mark  = wr_a_q.size();
        rd_mark  = rd_total;
        @(negedge clk);
        base_addr = b; word_count = n; seed = sd; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    chk("err_count_at_done", err_count, exp_err);
                    chk("pass_at_done", pass, exp_pass);
                    chk("busy_at_done", busy, 1'b0);
`ifdef FIRST_ERR_CAPTURE_EN
                    chk("first_err_addr", first_err_addr, exp_fa);
                    chk("first_err_data", first_err_data, exp_fd);
`endif
                end
            end
            if (c == 1 && n != 16'd0) chk("busy_running", busy, 1'b1);
            if (c > hold_at && c <= hold_at + hold_len) begin
                chk("hold_clken", bus.avm_clken, 1'b0);
                chk("hold_addr", bus.avm_address, snap_a);
                chk("hold_wdata", bus.avm_writedata, snap_d);
                chk("hold_cs_wr", {bus.avm_chipselect, bus.avm_write}, {snap_cs, snap_w});
            end
            if (c == hold_at) begin
                snap_a = bus.avm_address; snap_d = bus.avm_writedata;
                snap_cs = bus.avm_chipselect; snap_w = bus.avm_write;
            end
            hold = (c >= hold_at && c < hold_at + hold_len);
            if (done_cyc >= 0 && c >= done_cyc + 8) break;
        end
        start = 1'b0; hold = 1'b0;
        chk("done_cycle", done_cyc, exp_done);
        chk("done_pulses", dones, 1);
        chk("pass_held", pass, exp_pass);
        nw = wr_a_q.size() - wr_mark;
        chk("write_count", nw, n);
        chk("read_count", rd_total - rd_mark, n);
        for (int i = 0; i < int'(n) && i < nw; i++) begin
            chk($sformatf("wr_addr[%0d]", i), wr_a_q[wr_mark + i], (int'(b) + i) % DEPTH);
            chk($sformatf("wr_data[%0d]", i), wr_d_q[wr_mark + i], pat(sd, i));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy_done_pass"}, {busy, done, pass}, 3'b000);
        chk({tag, "_err_count"}, err_count, 16'd0);
        chk({tag, "_cs_write"}, {bus.avm_chipselect, bus.avm_write}, 2'b00);
        chk({tag, "_address"}, bus.avm_address, 15'd0);
        chk({tag, "_writedata"}, bus.avm_writedata, 32'd0);
        chk({tag, "_byteenable"}, bus.avm_byteenable, 4'hF);
`ifdef FIRST_ERR_CAPTURE_EN
        chk({tag, "_first_err"}, {first_err_addr, first_err_data}, 47'd0);
`endif
    endtask

    typedef struct {
        logic [14:0] base;
        logic [15:0] n;
        logic [31:0] sd;
        bit          flt;
        int          hold_at;
        int          hold_len;
        int          restart_at;
        int          exp_done;
        logic [15:0] exp_err;
        bit          exp_pass;
        logic [14:0] exp_fa;
        logic [31:0] exp_fd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [14:0] rb;
        logic [15:0] rn, re;
        logic [31:0] rs, rfd;
        logic [14:0] rfa;
        bit          rflt;
        int          rh, rl, mode, mark;

        tbl[0] = '{15'd0,     16'd4,  32'h00000000, 1'b0, -1, 0, -1, 10, 16'd0, 1'b1, 15'd0, 32'h0};
        tbl[1] = '{15'd30718, 16'd4,  32'h12345678, 1'b0, -1, 0, -1, 10, 16'd0, 1'b1, 15'd0, 32'h0};
        tbl[2] = '{15'd0,     16'd8,  32'hA5A5A5A5, 1'b1, -1, 0, -1, 18, 16'd1, 1'b0, 15'd5, 32'h5A5FA5A1};
        tbl[3] = '{15'd200,   16'd6,  32'h00000001, 1'b0,  3, 3, -1, 17, 16'd0, 1'b1, 15'd0, 32'h0};
        tbl[4] = '{15'd0,     16'd0,  32'hCAFEF00D, 1'b0, -1, 0, -1,  1, 16'd0, 1'b1, 15'd0, 32'h0};
        tbl[5] = '{15'd1000,  16'd16, 32'hDEADBEEF, 1'b0, -1, 0,  5, 34, 16'd0, 1'b1, 15'd0, 32'h0};
        tbl[6] = '{15'd50,    16'd2,  32'h0F0F0F0F, 1'b0, -1, 0,  6,  6, 16'd0, 1'b1, 15'd0, 32'h0};
        tbl[7] = '{15'd4,     16'd4,  32'h11111111, 1'b1, -1, 0, -1, 10, 16'd1, 1'b0, 15'd5, 32'hEEEF1111};
        tbl[8] = '{15'd10,    16'd5,  32'h00000000, 1'b1, -1, 0, -1, 12, 16'd0, 1'b1, 15'd0, 32'h0};
        tbl[9] = '{15'd30719, 16'd8,  32'h00000000, 1'b1, -1, 0, -1, 18, 16'd1, 1'b0, 15'd5, 32'hFFF90007};

        // Reset state while reset_n is held low.
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_clken", bus.avm_clken, 1'b1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            run_test(tbl[v].base, tbl[v].n, tbl[v].sd, tbl[v].flt, tbl[v].hold_at, tbl[v].hold_len,
                     tbl[v].restart_at, tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_pass,
                     tbl[v].exp_fa, tbl[v].exp_fd);
        end

        // Reset in the middle of the read pass, at read index 3.
        fault_en = 1'b0;
        @(negedge clk);
        base_addr = 15'd100; word_count = 16'd8; seed = 32'h5555AAAA; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_read3", {bus.avm_chipselect, bus.avm_write, bus.avm_address}, {2'b10, 15'd103});
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        mark = wr_a_q.size();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_write_after_reset", wr_a_q.size() - mark, 0);
        run_test(15'd300, 16'd2, 32'h13579BDF, 1'b0, -1, 0, -1, 6, 16'd0, 1'b1, 15'd0, 32'h0);

        // Randomized runs checked against the memory-image model.
        for (int r = 0; r < 20; r++) begin
            mode = $urandom_range(0, 2);
            case (mode)
                0:       rb = 15'($urandom_range(0, DEPTH - 1));
                1:       rb = 15'(DEPTH - 1 - $urandom_range(0, 10));
                default: rb = 15'($urandom_range(0, 6));
            endcase
            rn   = 16'($urandom_range(0, 40));
            rs   = $urandom;
            rflt = 1'($urandom_range(0, 1));
            rh = -1; rl = 0;
            if (rn != 16'd0 && $urandom_range(0, 1) == 1) begin
                rh = $urandom_range(1, 2 * int'(rn) + 1);
                rl = $urandom_range(1, 4);
            end
            model(int'(rb), int'(rn), rs, rflt, re, rfa, rfd);
            run_test(rb, rn, rs, rflt, rh, rl, -1,
                     (rn == 16'd0) ? 1 : 2 * int'(rn) + 2 + rl,
                     re, (re == 16'd0), rfa, rfd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end
endmodule
